// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V memory-stage load/store unit.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } lsu_state_t;

   // funct3 encodings of the load/store size and signedness
   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_D  = 3'b011;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;
   localparam logic [2:0] LSU_WU = 3'b110;

   // access size from funct3[1:0]
   localparam logic [1:0] LSU_SZ_B = 2'd0;
   localparam logic [1:0] LSU_SZ_H = 2'd1;
   localparam logic [1:0] LSU_SZ_W = 2'd2;
   localparam logic [1:0] LSU_SZ_D = 2'd3;

   // byte-enable patterns before lane shifting
   localparam logic [7:0] LSU_STRB_B = 8'h01;
   localparam logic [7:0] LSU_STRB_H = 8'h03;
   localparam logic [7:0] LSU_STRB_W = 8'h0F;
   localparam logic [7:0] LSU_STRB_D = 8'hFF;

   localparam int unsigned LSU_CNT_W = 8;

   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3)
         LSU_H, LSU_HU: mis = addr_lo[0];
         LSU_W, LSU_WU: mis = |addr_lo[1:0];
         LSU_D:         mis = |addr_lo;
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store data replication and strobes, load extraction
// and sign/zero extension, misalignment detection.
module riscv_lsu_align
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [2:0]      m_funct3,
   input  logic [2:0]      m_addr_lo,
   input  logic [XLEN-1:0] m_storedata,
   input  logic [2:0]      ld_funct3,
   input  logic [2:0]      ld_lane,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] st_wdata_c,
   output logic [7:0]      st_wstrb_c,
   output logic            misalign_c,
   output logic [XLEN-1:0] ld_data_c
);

   logic [XLEN-1:0] ld_shift;

   assign misalign_c = lsu_misaligned(m_funct3, m_addr_lo);

   // Store side: replicate the operand into every lane, enable only the addressed bytes
   always_comb begin
      st_wdata_c = m_storedata;
      st_wstrb_c = LSU_STRB_D;
      case (m_funct3[1:0])
         LSU_SZ_B: begin
            st_wdata_c = {(XLEN/8){m_storedata[7:0]}};
            st_wstrb_c = LSU_STRB_B << m_addr_lo;
         end
         LSU_SZ_H: begin
            st_wdata_c = {(XLEN/16){m_storedata[15:0]}};
            st_wstrb_c = LSU_STRB_H << m_addr_lo;
         end
         LSU_SZ_W: begin
            st_wdata_c = {(XLEN/32){m_storedata[31:0]}};
            st_wstrb_c = LSU_STRB_W << m_addr_lo;
         end
         default: begin
            st_wdata_c = m_storedata;
            st_wstrb_c = LSU_STRB_D;
         end
      endcase
   end

   assign ld_shift = ld_rdata >> {ld_lane, 3'b000};

   // Load side: bring the addressed lane to bit 0 and extend
   always_comb begin
      ld_data_c = ld_shift;
      case (ld_funct3)
         LSU_B:   ld_data_c = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
         LSU_BU:  ld_data_c = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
         LSU_H:   ld_data_c = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
         LSU_HU:  ld_data_c = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
         LSU_W:   ld_data_c = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
         LSU_WU:  ld_data_c = {{(XLEN-32){1'b0}},         ld_shift[31:0]};
         default: ld_data_c = ld_shift;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit: req/ack bus sequencing, pipeline hold, capture registers.
// Optional bus timeout with access fault when RISCV_LSU_TIMEOUT_EN is defined.
module riscv_lsu
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic            i_riscv_lsu_clk,
   input  logic            i_riscv_lsu_rstn,
   input  logic            i_riscv_lsu_memread_m,
   input  logic            i_riscv_lsu_memwrite_m,
   input  logic [2:0]      i_riscv_lsu_funct3_m,
   input  logic [XLEN-1:0] i_riscv_lsu_addr_m,
   input  logic [XLEN-1:0] i_riscv_lsu_storedata_m,
   input  logic            i_riscv_lsu_flush,
   output logic            o_riscv_lsu_stall,
   output logic [XLEN-1:0] o_riscv_lsu_memload_m,
   output logic            o_riscv_lsu_ld_misalign,
   output logic            o_riscv_lsu_st_misalign,
   output logic            o_riscv_lsu_accessfault,
   output logic            o_riscv_lsu_req,
   output logic            o_riscv_lsu_we,
   output logic [XLEN-1:0] o_riscv_lsu_addr,
   output logic [XLEN-1:0] o_riscv_lsu_wdata,
   output logic [7:0]      o_riscv_lsu_wstrb,
   input  logic            i_riscv_lsu_ack,
   input  logic [XLEN-1:0] i_riscv_lsu_rdata
);

   lsu_state_t      state_q;
   logic [2:0]      ld_funct3_q;
   logic [2:0]      ld_lane_q;
   logic            fault_q;
   logic            op_c;
   logic            is_load_c;
   logic            misalign_c;
   logic            launch_c;
   logic            tmo_hit_c;
   logic [XLEN-1:0] wdata_c;
   logic [7:0]      wstrb_c;
   logic [XLEN-1:0] ld_data_c;

   riscv_lsu_align #(.XLEN(XLEN)) u_align (
      .m_funct3    (i_riscv_lsu_funct3_m),
      .m_addr_lo   (i_riscv_lsu_addr_m[2:0]),
      .m_storedata (i_riscv_lsu_storedata_m),
      .ld_funct3   (ld_funct3_q),
      .ld_lane     (ld_lane_q),
      .ld_rdata    (i_riscv_lsu_rdata),
      .st_wdata_c  (wdata_c),
      .st_wstrb_c  (wstrb_c),
      .misalign_c  (misalign_c),
      .ld_data_c   (ld_data_c)
   );

   // A simultaneous read+write is handled as a store
   assign op_c      = i_riscv_lsu_memread_m | i_riscv_lsu_memwrite_m;
   assign is_load_c = i_riscv_lsu_memread_m & ~i_riscv_lsu_memwrite_m;

   // The cycle after a timeout fault the faulting op is still in M; do not relaunch it
   assign launch_c = (state_q == IDLE) & op_c & ~misalign_c & ~i_riscv_lsu_flush & ~fault_q;

   // Held low during reset so that every output reads 0 while rstn is asserted
   assign o_riscv_lsu_stall = i_riscv_lsu_rstn &
                              (launch_c | (state_q == BUSY) | ((state_q == DRAIN) & op_c));
   assign o_riscv_lsu_ld_misalign = i_riscv_lsu_rstn & (state_q == IDLE) & is_load_c & misalign_c;
   assign o_riscv_lsu_st_misalign = i_riscv_lsu_rstn & (state_q == IDLE) &
                                    i_riscv_lsu_memwrite_m & misalign_c;
   assign o_riscv_lsu_accessfault = fault_q;

`ifdef RISCV_LSU_TIMEOUT_EN
   localparam logic [LSU_CNT_W-1:0] TMO_LAST = LSU_CNT_W'(TIMEOUT_CYC - 1);

   logic [LSU_CNT_W-1:0] tmo_cnt_q;

   assign tmo_hit_c = (tmo_cnt_q == TMO_LAST);

   // Counts wait cycles; restarts on every entry to BUSY or DRAIN
   always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rstn) begin
      if (!i_riscv_lsu_rstn) begin
         tmo_cnt_q <= '0;
      end else if (launch_c || (state_q == BUSY && i_riscv_lsu_flush && !i_riscv_lsu_ack)) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == BUSY || state_q == DRAIN) && !i_riscv_lsu_ack) begin
         tmo_cnt_q <= tmo_cnt_q + LSU_CNT_W'(1);
      end
   end
`else
   logic timeout_unused;

   assign timeout_unused = ^LSU_CNT_W'(TIMEOUT_CYC);
   assign tmo_hit_c      = 1'b0;
`endif

   // Transaction FSM with registered bus outputs and load result
   always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rstn) begin
      if (!i_riscv_lsu_rstn) begin
         state_q               <= IDLE;
         o_riscv_lsu_req       <= 1'b0;
         o_riscv_lsu_we        <= 1'b0;
         o_riscv_lsu_addr      <= '0;
         o_riscv_lsu_wdata     <= '0;
         o_riscv_lsu_wstrb     <= '0;
         o_riscv_lsu_memload_m <= '0;
         ld_funct3_q           <= '0;
         ld_lane_q             <= '0;
         fault_q               <= 1'b0;
      end else begin
         fault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch_c) begin
                  o_riscv_lsu_req   <= 1'b1;
                  o_riscv_lsu_we    <= i_riscv_lsu_memwrite_m;
                  o_riscv_lsu_addr  <= {i_riscv_lsu_addr_m[XLEN-1:3], 3'b000};
                  o_riscv_lsu_wdata <= i_riscv_lsu_memwrite_m ? wdata_c : '0;
                  o_riscv_lsu_wstrb <= i_riscv_lsu_memwrite_m ? wstrb_c : 8'h00;
                  ld_funct3_q       <= i_riscv_lsu_funct3_m;
                  ld_lane_q         <= i_riscv_lsu_addr_m[2:0];
                  state_q           <= BUSY;
               end
            end
            BUSY: begin
               if (i_riscv_lsu_ack) begin
                  o_riscv_lsu_req <= 1'b0;
                  if (i_riscv_lsu_flush) begin
                     state_q <= IDLE;
                  end else begin
                     o_riscv_lsu_memload_m <= o_riscv_lsu_we ? '0 : ld_data_c;
                     state_q               <= DONE;
                  end
               end else if (i_riscv_lsu_flush) begin
                  state_q <= DRAIN;
               end else if (tmo_hit_c) begin
                  fault_q         <= 1'b1;
                  o_riscv_lsu_req <= 1'b0;
                  state_q         <= IDLE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            DRAIN: begin
               // The bus cannot abort, so wait out the ack and drop its data
               if (i_riscv_lsu_ack || tmo_hit_c) begin
                  o_riscv_lsu_req <= 1'b0;
                  state_q         <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads, stores, misalignment, flush/drain, reset, optional timeout.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rstn;
   logic        memread;
   logic        memwrite;
   logic [2:0]  funct3;
   logic [63:0] addr_m;
   logic [63:0] storedata;
   logic        flush;
   logic        stall;
   logic [63:0] memload;
   logic        ld_mis;
   logic        st_mis;
   logic        accessfault;
   logic        req;
   logic        we;
   logic [63:0] bus_addr;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        ack;
   logic [63:0] rdata;

   int n_tests = 0;
   int n_fail  = 0;

   int          n_stall;
   logic        obs_we;
   logic [63:0] obs_addr;
   logic [63:0] obs_wdata;
   logic [7:0]  obs_wstrb;
   logic [63:0] obs_load;

   riscv_lsu #(.XLEN(64), .TIMEOUT_CYC(4)) dut (
      .i_riscv_lsu_clk         (clk),
      .i_riscv_lsu_rstn        (rstn),
      .i_riscv_lsu_memread_m   (memread),
      .i_riscv_lsu_memwrite_m  (memwrite),
      .i_riscv_lsu_funct3_m    (funct3),
      .i_riscv_lsu_addr_m      (addr_m),
      .i_riscv_lsu_storedata_m (storedata),
      .i_riscv_lsu_flush       (flush),
      .o_riscv_lsu_stall       (stall),
      .o_riscv_lsu_memload_m   (memload),
      .o_riscv_lsu_ld_misalign (ld_mis),
      .o_riscv_lsu_st_misalign (st_mis),
      .o_riscv_lsu_accessfault (accessfault),
      .o_riscv_lsu_req         (req),
      .o_riscv_lsu_we          (we),
      .o_riscv_lsu_addr        (bus_addr),
      .o_riscv_lsu_wdata       (wdata),
      .o_riscv_lsu_wstrb       (wstrb),
      .i_riscv_lsu_ack         (ack),
      .i_riscv_lsu_rdata       (rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Present one op in M and serve it; ack arrives in BUSY cycle number ack_at
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd,
                         input int ack_at, input logic [63:0] rdat);
      int busy;
      busy    = 0;
      n_stall = 0;
      @(negedge clk);
      memread = rd; memwrite = wr; funct3 = f3; addr_m = a; storedata = sd; ack = 1'b0;
      #1;
      for (int cyc = 0; cyc < 40 && stall; cyc++) begin
         n_stall++;
         @(negedge clk);
         ack = 1'b0;
         if (req) begin
            busy++;
            if (busy == 1) begin
               obs_we = we; obs_addr = bus_addr; obs_wdata = wdata; obs_wstrb = wstrb;
            end
            if (busy == ack_at) begin
               ack   = 1'b1;
               rdata = rdat;
            end
         end
         #1;
      end
      check_eq("op_stall_released", 64'(stall), 64'd0);
      obs_load = memload;
      memread  = 1'b0;
      memwrite = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int fault_at;
      rstn = 1'b0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'b000; addr_m = '0;
      storedata = '0; flush = 1'b0; ack = 1'b0; rdata = '0;
      obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_load = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_req",     64'(req),         64'd0);
      check_eq("rst_stall",   64'(stall),       64'd0);
      check_eq("rst_memload", memload,          64'd0);
      check_eq("rst_wstrb",   64'(wstrb),       64'd0);
      check_eq("rst_fault",   64'(accessfault), 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // LW 0x1004, ack in 2nd BUSY cycle
      run_op(1'b1, 1'b0, 3'b010, 64'h1004, 64'h0, 2, 64'h8000_0001_0000_0000);
      check_eq("lw_addr",    obs_addr,      64'h1000);
      check_eq("lw_we",      64'(obs_we),   64'd0);
      check_eq("lw_stall_n", 64'(n_stall),  64'd3);
      check_eq("lw_load",    obs_load,      64'hFFFF_FFFF_8000_0001);

      // SB 0x2003, ack in 1st BUSY cycle
      run_op(1'b0, 1'b1, 3'b000, 64'h2003, 64'h0000_0000_0000_00AB, 1, 64'h0);
      check_eq("sb_we",      64'(obs_we),    64'd1);
      check_eq("sb_addr",    obs_addr,       64'h2000);
      check_eq("sb_wstrb",   64'(obs_wstrb), 64'h08);
      check_eq("sb_wdata",   obs_wdata,      64'hABAB_ABAB_ABAB_ABAB);
      check_eq("sb_stall_n", 64'(n_stall),   64'd2);
      check_eq("sb_memload", obs_load,       64'd0);

      // SW 0x2004 with junk in the upper operand bits
      run_op(1'b0, 1'b1, 3'b010, 64'h2004, 64'hFFFF_0000_1234_5678, 1, 64'h0);
      check_eq("sw_wstrb", 64'(obs_wstrb), 64'hF0);
      check_eq("sw_wdata", obs_wdata,      64'h1234_5678_1234_5678);

      // Misaligned LH and SD: no request, no stall
      @(negedge clk);
      memread = 1'b1; funct3 = 3'b001; addr_m = 64'h3001;
      #1;
      check_eq("lh_mis_flag",  64'(ld_mis), 64'd1);
      check_eq("lh_mis_stall", 64'(stall),  64'd0);
      @(negedge clk);
      #1;
      check_eq("lh_mis_req",   64'(req),    64'd0);
      memread = 1'b0; memwrite = 1'b1; funct3 = 3'b011; addr_m = 64'h3004;
      #1;
      check_eq("sd_mis_flag",  64'(st_mis), 64'd1);
      check_eq("sd_mis_ld",    64'(ld_mis), 64'd0);
      @(negedge clk);
      memwrite = 1'b0;
      #1;
      check_eq("sd_mis_req",   64'(req),    64'd0);

      // Byte loads from the top lane
      run_op(1'b1, 1'b0, 3'b100, 64'h4007, 64'h0, 1, 64'hF000_0000_0000_0000);
      check_eq("lbu_load", obs_load, 64'h0000_0000_0000_00F0);
      run_op(1'b1, 1'b0, 3'b000, 64'h4007, 64'h0, 1, 64'hF000_0000_0000_0000);
      check_eq("lb_load",  obs_load, 64'hFFFF_FFFF_FFFF_FFF0);

      // Flush one cycle into BUSY, ack three cycles later
      @(negedge clk);
      memread = 1'b1; funct3 = 3'b011; addr_m = 64'h5000;
      #1;
      check_eq("fl_idle_stall", 64'(stall), 64'd1);
      @(negedge clk);
      #1;
      check_eq("fl_busy_req", 64'(req), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check_eq("fl_flush_stall", 64'(stall), 64'd1);
      @(negedge clk);
      flush = 1'b0; memread = 1'b0;
      #1;
      check_eq("fl_drain_req",   64'(req),   64'd1);
      check_eq("fl_drain_stall", 64'(stall), 64'd0);
      @(negedge clk);
      memread = 1'b1; addr_m = 64'h5008;
      #1;
      check_eq("fl_drain_newop_stall", 64'(stall), 64'd1);
      @(negedge clk);
      memread = 1'b0; ack = 1'b1; rdata = 64'hDEAD_BEEF_0000_1111;
      #1;
      check_eq("fl_ack_req",   64'(req),   64'd1);
      check_eq("fl_ack_stall", 64'(stall), 64'd0);
      @(negedge clk);
      ack = 1'b0;
      #1;
      check_eq("fl_idle_req",   64'(req),   64'd0);
      check_eq("fl_memload",    memload,    64'hFFFF_FFFF_FFFF_FFF0);
      check_eq("fl_idle_stall2", 64'(stall), 64'd0);
      @(negedge clk);
      #1;
      check_eq("fl_memload2", memload, 64'hFFFF_FFFF_FFFF_FFF0);

      // Halfword loads and a doubleword with a longer wait
      run_op(1'b1, 1'b0, 3'b101, 64'h4006, 64'h0, 1, 64'hF000_0000_0000_0000);
      check_eq("lhu_load", obs_load, 64'h0000_0000_0000_F000);
      run_op(1'b1, 1'b0, 3'b001, 64'h4006, 64'h0, 1, 64'hF000_0000_0000_0000);
      check_eq("lh_load",  obs_load, 64'hFFFF_FFFF_FFFF_F000);
      run_op(1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 3, 64'h0123_4567_89AB_CDEF);
      check_eq("ld_load",    obs_load,     64'h0123_4567_89AB_CDEF);
      check_eq("ld_stall_n", 64'(n_stall), 64'd4);

`ifdef RISCV_LSU_TIMEOUT_EN
      // No ack: fault after four BUSY cycles
      @(negedge clk);
      memread = 1'b1; funct3 = 3'b010; addr_m = 64'h6000;
      pulses   = 0;
      fault_at = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (accessfault) begin
            pulses++;
            if (fault_at < 0) begin
               fault_at = c;
               check_eq("tmo_req_drop", 64'(req), 64'd0);
               memread = 1'b0;
            end
         end
      end
      check_eq("tmo_pulses", 64'(pulses),   64'd1);
      check_eq("tmo_cycle",  64'(fault_at), 64'd4);
      check_eq("tmo_idle",   64'(req),      64'd0);
`endif

      // Asynchronous reset in the middle of a store
      @(negedge clk);
      memwrite = 1'b1; funct3 = 3'b011; addr_m = 64'h7000; storedata = 64'h1122_3344_5566_7788;
      @(negedge clk);
      #1;
      check_eq("mrst_busy_req", 64'(req), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("mrst_req",     64'(req),   64'd0);
      check_eq("mrst_stall",   64'(stall), 64'd0);
      check_eq("mrst_we",      64'(we),    64'd0);
      check_eq("mrst_addr",    bus_addr,   64'd0);
      check_eq("mrst_wdata",   wdata,      64'd0);
      check_eq("mrst_wstrb",   64'(wstrb), 64'd0);
      check_eq("mrst_memload", memload,    64'd0);
      memwrite = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      #1;
      check_eq("post_rst_req", 64'(req), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
